// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, function codes,
// ALU control codes, the control FSM state type and immediate sign extension.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEMADR,
      S_MEMRD,
      S_MEMWR,
      S_WB_R,
      S_WB_I,
      S_WB_MEM
   } state_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two architectural read ports, one debug read port and
// one synchronous write port. Register 0 always reads zero.
module mips_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  dbg_sel,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] dbg_data
);

   logic [31:0] regs [32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   // Reads are asynchronous, so a same-cycle write is only visible next cycle.
   assign rd1      = (ra1 == 5'd0)     ? '0 : regs[ra1];
   assign rd2      = (ra2 == 5'd0)     ? '0 : regs[ra2];
   assign dbg_data = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle 32-bit MIPS core sharing one instruction/data memory port with a
// req/ready handshake; a control FSM walks fetch, decode, execute, memory, writeback.
module mips_multicycle_core
   import mips_pkg::*;
#(
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   input  logic [4:0]        dbg_sel,
   output logic [31:0]       dbg_data,
   output logic              instr_done,
   output logic              illegal
);

   state_t      state;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_out;
   logic [31:0] mdr;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [31:0] imm_ext;
   logic [31:0] br_target;

   logic [31:0] rf_rd1;
   logic [31:0] rf_rd2;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   logic [2:0]  alu_ctl;
   logic [31:0] alu_src_b;
   logic signed [31:0] alu_a_s;
   logic signed [31:0] alu_b_s;
   logic [31:0] alu_y;

   logic        r_legal;
   logic        op_legal;
   logic        needs_exec;
   logic        dec_retire;

   assign opcode    = ir[31:26];
   assign rs        = ir[25:21];
   assign rt        = ir[20:16];
   assign rd        = ir[15:11];
   assign shamt     = ir[10:6];
   assign funct     = ir[5:0];
   assign imm_ext   = sext16(ir[15:0]);
   // pc has already advanced past the branch when this is used in DECODE.
   assign br_target = pc + {imm_ext[29:0], 2'b00};

   mips_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .ra1      (rs),
      .ra2      (rt),
      .dbg_sel  (dbg_sel),
      .we       (rf_we),
      .wa       (rf_wa),
      .wd       (rf_wd),
      .rd1      (rf_rd1),
      .rd2      (rf_rd2),
      .dbg_data (dbg_data)
   );

   always_comb begin
      r_legal = 1'b0;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: r_legal = (shamt == 5'd0);
         default: r_legal = 1'b0;
      endcase
      op_legal = 1'b0;
      case (opcode)
         OP_RTYPE: op_legal = r_legal;
         OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
      needs_exec = (opcode == OP_RTYPE) || (opcode == OP_ADDI) ||
                   (opcode == OP_LW)    || (opcode == OP_SW);
   end

   always_comb begin
      alu_ctl = ALU_ADD;
      if (state == S_EXEC_R) begin
         case (funct)
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: alu_ctl = ALU_ADD;
         endcase
      end
   end

   assign alu_src_b = (state == S_EXEC_R) ? b : imm_ext;
   assign alu_a_s   = a;
   assign alu_b_s   = alu_src_b;

   always_comb begin
      alu_y = '0;
      case (alu_ctl)
         ALU_AND: alu_y = a & alu_src_b;
         ALU_OR:  alu_y = a | alu_src_b;
         ALU_ADD: alu_y = a + alu_src_b;
         ALU_SUB: alu_y = a - alu_src_b;
         ALU_SLT: alu_y = {31'd0, (alu_a_s < alu_b_s)};
         default: alu_y = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir    <= mem_rdata;
                  pc    <= pc + 32'd4;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               a     <= rf_rd1;
               b     <= rf_rd2;
               state <= S_FETCH;
               // Illegal encodings fall through and retire as a NOP.
               if (op_legal) begin
                  case (opcode)
                     OP_RTYPE: state <= S_EXEC_R;
                     OP_ADDI:  state <= S_EXEC_I;
                     OP_LW,
                     OP_SW:    state <= S_MEMADR;
                     OP_BEQ:   if (rf_rd1 == rf_rd2) pc <= br_target;
                     OP_BNE:   if (rf_rd1 != rf_rd2) pc <= br_target;
                     OP_J:     pc <= {pc[31:28], ir[25:0], 2'b00};
                     default:  state <= S_FETCH;
                  endcase
               end
            end
            S_EXEC_R: begin
               alu_out <= alu_y;
               state   <= S_WB_R;
            end
            S_EXEC_I: begin
               alu_out <= alu_y;
               state   <= S_WB_I;
            end
            S_MEMADR: begin
               alu_out <= alu_y;
               state   <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               if (mem_ready) begin
                  mdr   <= mem_rdata;
                  state <= S_WB_MEM;
               end
            end
            S_MEMWR: begin
               if (mem_ready) state <= S_FETCH;
            end
            S_WB_R, S_WB_I, S_WB_MEM: state <= S_FETCH;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Memory-side outputs decode the state register; reset gating makes an
   // asserted reset abort any transaction immediately.
   assign mem_req   = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !reset;
   assign mem_we    = (state == S_MEMWR) && !reset;
   assign mem_addr  = (state == S_FETCH) ? {pc[ADDR_W-1:2], 2'b00}
                                         : {alu_out[ADDR_W-1:2], 2'b00};
   assign mem_wdata = b;

   assign dec_retire = (state == S_DECODE) && !(op_legal && needs_exec);
   assign instr_done = dec_retire ||
                       ((state == S_MEMWR) && mem_ready) ||
                       (state == S_WB_R) || (state == S_WB_I) || (state == S_WB_MEM);
   assign illegal    = (state == S_DECODE) && !op_legal;

   assign rf_we = (state == S_WB_R) || (state == S_WB_I) || (state == S_WB_MEM);
   assign rf_wa = (state == S_WB_R) ? rd : rt;
   assign rf_wd = (state == S_WB_MEM) ? mdr : alu_out;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a wait-state memory plus an ISA-level
// reference model checked every cycle, with hand-computed literal expectations.
module tb_mips_multicycle_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [4:0]  dbg_sel = 5'd0;
   logic [31:0] dbg_data;
   logic        instr_done;
   logic        illegal;

   int tests = 0;
   int fails = 0;

   logic [31:0] img  [256];
   logic [31:0] mem  [256];
   logic [31:0] mmem [256];
   logic [31:0] mregs [32];
   logic [31:0] mpc;
   logic        load_en = 1'b0;
   int          wait_n = 0;
   int          cnt = 0;
   int          writes = 0;

   int cyc, waits, txn, cyc_total, retires, cyc3, ill_cnt, hold_cnt;
   logic [31:0] fetch_log [$];

   mips_multicycle_core #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   assign mem_ready = mem_req && (cnt >= wait_n);
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (reset) begin
         cnt <= 0;
         if (load_en) for (int k = 0; k < 256; k++) mem[k] <= img[k];
      end else if (mem_req && mem_ready) begin
         cnt <= 0;
         if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            writes <= writes + 1;
         end
      end else if (mem_req) begin
         cnt <= cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   function automatic bit legal(input logic [31:0] i);
      case (i[31:26])
         6'h00: return (i[10:6] == 5'd0) &&
                       (i[5:0] == 6'h20 || i[5:0] == 6'h22 || i[5:0] == 6'h24 ||
                        i[5:0] == 6'h25 || i[5:0] == 6'h2A);
         6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int base_lat(input logic [31:0] i);
      if (!legal(i)) return 2;
      case (i[31:26])
         6'h23:        return 5;
         6'h00, 6'h08, 6'h2B: return 4;
         default:      return 2;
      endcase
   endfunction

   function automatic int beats(input logic [31:0] i);
      return (legal(i) && (i[31:26] == 6'h23 || i[31:26] == 6'h2B)) ? 2 : 1;
   endfunction

   task automatic model_exec(input logic [31:0] i);
      logic [31:0] nxt, se, x, y, ea;
      nxt = mpc + 32'd4;
      se  = {{16{i[15]}}, i[15:0]};
      x   = mregs[i[25:21]];
      y   = mregs[i[20:16]];
      ea  = x + se;
      if (legal(i)) begin
         case (i[31:26])
            6'h00: case (i[5:0])
               6'h20: mregs[i[15:11]] = x + y;
               6'h22: mregs[i[15:11]] = x - y;
               6'h24: mregs[i[15:11]] = x & y;
               6'h25: mregs[i[15:11]] = x | y;
               default: mregs[i[15:11]] = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            endcase
            6'h08: mregs[i[20:16]] = ea;
            6'h23: mregs[i[20:16]] = mmem[ea[9:2]];
            6'h2B: mmem[ea[9:2]] = y;
            6'h04: if (x == y) nxt = nxt + (se << 2);
            6'h05: if (x != y) nxt = nxt + (se << 2);
            default: nxt = {nxt[31:28], i[25:0], 2'b00};
         endcase
      end
      mregs[0] = 32'd0;
      mpc = nxt;
   endtask

   // Reference-model compare process, evaluated mid-cycle.
   initial forever begin
      logic [31:0] cur, ea;
      @(negedge clk);
      if (reset) begin
         if (load_en) for (int k = 0; k < 256; k++) mmem[k] = img[k];
         for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
         mpc = 32'h0;
         cyc = 0; waits = 0; txn = 0; cyc_total = 0; retires = 0;
         ill_cnt = 0; hold_cnt = 0;
         fetch_log.delete();
      end else begin
         cur = mmem[mpc[9:2]];
         ea  = mregs[cur[25:21]] + {{16{cur[15]}}, cur[15:0]};
         cyc++;
         cyc_total++;
         if (mem_req && mem_we) hold_cnt++;
         if (illegal) ill_cnt++;
         if (mem_req) begin
            if (txn == 0) begin
               if (cyc == 1) fetch_log.push_back(32'(mem_addr));
               chk("fetch_addr", 32'(mem_addr), mpc & 32'h3FF);
               chk("fetch_we", 32'(mem_we), 32'd0);
            end else if (txn < beats(cur)) begin
               chk("data_addr", 32'(mem_addr), {22'd0, ea[9:2], 2'b00});
               chk("data_we", 32'(mem_we), 32'(cur[31:26] == 6'h2B));
               if (cur[31:26] == 6'h2B) chk("store_data", mem_wdata, mregs[cur[20:16]]);
            end else begin
               chk("extra_beat", 32'(txn), 32'(beats(cur) - 1));
            end
            if (mem_ready) txn++;
            else waits++;
         end
         chk("illegal", 32'(illegal), 32'(instr_done && !legal(cur)));
         if (instr_done) begin
            chk("latency", 32'(cyc), 32'(base_lat(cur) + waits));
            chk("beats", 32'(txn), 32'(beats(cur)));
            if (retires == 2) cyc3 = cyc_total;
            model_exec(cur);
            retires++;
            cyc = 0; waits = 0; txn = 0;
         end
      end
   end

   task automatic do_reset(input bit load);
      load_en = load;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      load_en = 1'b0;
   endtask

   task automatic run_until(input int n, input int maxc);
      int c;
      c = 0;
      while (retires < n && c < maxc) begin
         @(posedge clk);
         c++;
      end
      if (retires < n) chk("retire_timeout", 32'(retires), 32'(n));
   endtask

   task automatic dbg_chk(input string nm, input logic [4:0] idx, input logic [31:0] exp);
      dbg_sel = idx;
      #1;
      chk(nm, dbg_data, exp);
   endtask

   task automatic sweep();
      for (int r = 0; r < 32; r++) begin
         dbg_sel = 5'(r);
         #1;
         chk("reg_vs_model", dbg_data, mregs[r]);
      end
      dbg_sel = 5'd0;
   endtask

   task automatic clear_img();
      for (int k = 0; k < 256; k++) img[k] = 32'd0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c;
      int writes_before;

      // Program A: arithmetic, then store/load with wait states.
      clear_img();
      img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
      img[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      img[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
      img[4] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
      img[5] = enc_j(26'h5);
      wait_n = 0;
      do_reset(1'b1);
      #1;
      chk("reset_req_state", 32'(mem_req), 32'd1);
      chk("reset_first_addr", 32'(mem_addr), 32'h0);
      writes_before = writes;
      run_until(3, 100);
      chk("three_instr_cycles", 32'(cyc3), 32'd12);
      dbg_chk("add_result", 5'd3, 32'd12);
      wait_n = 3;
      run_until(5, 200);
      wait_n = 0;
      dbg_chk("lw_result", 5'd4, 32'd12);
      chk("sw_hold_cycles", 32'(hold_cnt), 32'd4);
      chk("sw_write_count", 32'(writes - writes_before), 32'd1);
      chk("sw_mem_word", mem[2], 32'd12);
      sweep();

      // Program B: branches, jump, $0 protection, signed slt, illegal opcode.
      clear_img();
      img[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      img[1]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      img[2]  = enc_i(6'h05, 5'd1, 5'd1, 16'd2);
      img[3]  = enc_r(5'd0, 5'd1, 5'd5, 6'h22);
      img[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
      img[5]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
      img[6]  = enc_i(6'h08, 5'd0, 5'd6, 16'd2);
      img[7]  = enc_i(6'h05, 5'd1, 5'd1, 16'd2);
      img[8]  = enc_j(26'h10);
      img[9]  = enc_i(6'h08, 5'd0, 5'd6, 16'd3);
      img[16] = enc_r(5'd5, 5'd1, 5'd5, 6'h2A);
      img[17] = 32'hFC00_0000;
      img[18] = enc_r(5'd1, 5'd5, 5'd7, 6'h25);
      img[19] = enc_r(5'd1, 5'd5, 5'd8, 6'h24);
      img[20] = enc_j(26'h14);
      do_reset(1'b1);
      writes_before = writes;
      run_until(12, 300);
      if (fetch_log.size() >= 10) begin
         chk("bne_not_taken_fetch", fetch_log[3], 32'h0C);
         chk("beq_taken_fetch", fetch_log[5], 32'h1C);
         chk("bne_after_beq_fetch", fetch_log[6], 32'h20);
         chk("jump_fetch", fetch_log[7], 32'h40);
         chk("illegal_pc_plus4", fetch_log[9], 32'h48);
      end else begin
         chk("fetch_log_size", 32'(fetch_log.size()), 32'd10);
      end
      chk("illegal_pulses", 32'(ill_cnt), 32'd1);
      chk("no_mem_write", 32'(writes - writes_before), 32'd0);
      dbg_chk("zero_reg", 5'd0, 32'd0);
      dbg_chk("slt_signed", 5'd5, 32'd1);
      dbg_chk("skipped_reg", 5'd6, 32'd0);
      dbg_chk("or_result", 5'd7, 32'd5);
      dbg_chk("and_result", 5'd8, 32'd1);
      sweep();

      // Program C: reset asserted while a store waits for ready.
      clear_img();
      img[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd77);
      img[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'd12);
      img[2] = enc_j(26'h2);
      img[3] = 32'hDEAD_BEEF;
      wait_n = 10;
      do_reset(1'b1);
      for (c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mem_we) break;
      end
      if (c == 200) chk("store_start_timeout", 32'(c), 32'd0);
      repeat (2) @(negedge clk);
      writes_before = writes;
      #1 reset = 1'b1;
      #1;
      chk("abort_req", 32'(mem_req), 32'd0);
      chk("abort_we", 32'(mem_we), 32'd0);
      chk("abort_done", 32'(instr_done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      dbg_chk("reset_clears_reg", 5'd3, 32'd0);
      chk("abort_mem_unchanged", mem[3], 32'hDEAD_BEEF);
      chk("abort_no_write", 32'(writes - writes_before), 32'd0);
      wait_n = 0;
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("restart_req", 32'(mem_req), 32'd1);
      chk("restart_addr", 32'(mem_addr), 32'h0);
      run_until(3, 100);
      chk("rerun_store", mem[3], 32'd77);
      sweep();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
